fifo_wr_ptr_ctrl: RTL

//  Write-side pointer controller for a dual-clock FIFO, running entirely in the write clock domain.
//  - Sequences the RAM write address and a binary pointer.
//  - Publishes a Gray-coded write pointer for the read domain.
//  - Synchronises the Gray-coded read pointer and converts it to binary.
//  - Derives full, almost-full, fill level and a sticky overflow flag.
//  - Sits between the writer and the FIFO RAM; pairs with a mirror read-side controller.

---
 rtl/fifo_wr_ptr_ctrl.sv | 102 ++++++++++
 1 files changed

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-side pointer controller for a dual-clock FIFO (write clock domain).
// Sequences the RAM write address, publishes a Gray write pointer, synchronises
// the Gray read pointer and derives full / almost_full / level / overflow.
module fifo_wr_ptr_ctrl #(
  parameter int unsigned ADDR_W      = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned AF_MARGIN   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] waddr,
  input  logic [ADDR_W:0]   rptr_gray_in,
  output logic [ADDR_W:0]   wptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam logic [PTR_W-1:0] AF_THRESH = PTR_W'(DEPTH - AF_MARGIN);

  logic [PTR_W-1:0] wbin_q, wbin_d;
  logic [PTR_W-1:0] wgray_q, wgray_d;
  logic [PTR_W-1:0] sync_q [SYNC_STAGES];
  logic [PTR_W-1:0] rq;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] full_pat;
  logic [PTR_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             af_q, af_d;
  logic             ovf_q, ovf_d;

  // Accept is refused while full and forced low while reset is held.
  assign wr_ack      = wr_req & ~full_q & ~rst;
  assign waddr       = wbin_q[ADDR_W-1:0];
  assign wptr_gray   = wgray_q;
  assign full        = full_q;
  assign almost_full = af_q;
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign rq          = sync_q[SYNC_STAGES-1];

  // Next-state: pointer advance, Gray encode/decode, status flags.
  always_comb begin
    wbin_d   = wbin_q + PTR_W'(wr_ack);
    wgray_d  = wbin_d ^ (wbin_d >> 1);
    rbin     = '0;
    for (int i = 0; i < int'(PTR_W); i++) begin
      rbin[i] = ^(rq >> i);
    end
    full_pat = {~rq[ADDR_W:ADDR_W-1], rq[ADDR_W-2:0]};
    full_d   = (wgray_d == full_pat);
    level_d  = wbin_d - rbin;
    af_d     = (level_d >= AF_THRESH);
    ovf_d    = ovf_q;
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end
    if (wr_req && full_q) begin
      ovf_d = 1'b1;
    end
  end

  // Read-pointer synchroniser chain; rq is the last stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= rptr_gray_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      full_q  <= 1'b0;
      af_q    <= 1'b0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      full_q  <= full_d;
      af_q    <= af_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
